regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor of the core integer register file.
- Adds two write-back ports: port 0 for the ALU/single-cycle path, port 1 for the long-latency/LSU path.
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard that tracks pending long-latency writes.
- Sits between decode/issue (reads, busy checks, scoreboard set) and the write-back stage.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; reg 0 is hardwired to zero.
- RF_AW, 5, index width; must satisfy 2^RF_AW >= NREGS.
- BYPASS, 1, 1 = write-back data is forwarded to the read ports in the same cycle; 0 = reads see array contents only.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read_src1_idx  in  RF_AW  read port 1 index.
- read_src2_idx  in  RF_AW  read port 2 index.
- read_src1_dat  out  XLEN  read port 1 data (combinational).
- read_src2_dat  out  XLEN  read port 2 data (combinational).
- read_src1_busy  out  1  src1 register has a pending long-latency write.
- read_src2_busy  out  1  src2 register has a pending long-latency write.
- wbck0_wen  in  1  write enable, port 0 (ALU).
- wbck0_idx  in  RF_AW  write index, port 0.
- wbck0_dat  in  XLEN  write data, port 0.
- wbck1_wen  in  1  write enable, port 1 (long-latency); also clears busy.
- wbck1_idx  in  RF_AW  write index, port 1.
- wbck1_dat  in  XLEN  write data, port 1.
- sb_set_vld  in  1  issue of a long-latency op requests busy marking.
- sb_set_idx  in  RF_AW  destination register of that op.
- sb_set_rdy  out  1  set request is accepted this cycle.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- sb_cnt  out  RF_AW+1  number of busy registers.

Behaviour:
- Reset (rst_n low, async): all registers = 0, all busy bits = 0, sb_cnt = 0. Outputs follow combinationally from the cleared state.
- Register 0:
  - Reads always return 0 and busy 0.
  - Writes to index 0 are ignored.
  - A set to index 0 is accepted (sb_set_rdy = 1) with no effect.
  - Indices >= NREGS read 0 and busy 0; writes and sets to them are ignored.
- Writes take effect at the rising edge when wenX = 1 and idx != 0.
- Both ports writing the same index in one cycle: port 0 data wins. Port 1 still clears busy.
- Read data, BYPASS = 1, priority: wbck0 match (wen and idx equal, idx != 0), then wbck1 match, then array. BYPASS = 0: array only, so new data is visible the cycle after the write.
- Scoreboard:
  - sb_set_rdy = ~busy[sb_set_idx] | (wbck1_wen & wbck1_idx == sb_set_idx).
  - A set is accepted when sb_set_vld & sb_set_rdy; busy[idx] becomes 1 at the next edge.
  - Busy clear: at the edge, wbck1_wen clears busy[wbck1_idx].
  - Set and clear of the same index in one cycle: set wins (busy stays 1).
  - A clear of a non-busy register has no effect on busy or sb_cnt.
  - wbck0 never affects busy.
- read_srcN_busy = busy[idx], except that with BYPASS = 1 it is forced to 0 when wbck1 writes that idx in the same cycle.
- sb_cnt:
  - +1 on an accepted set of a non-busy register (idx != 0).
  - −1 on a clear of a busy register.
  - Both in one cycle: unchanged.
  - Accepted set of an already-busy register that is simultaneously cleared: unchanged.
  - Never wraps; the range is 0..NREGS-1.
- sb_flush has top priority: at the edge all busy bits = 0 and sb_cnt = 0. Register writes in that cycle still occur.

Test Plan:
- Reset then read x5/x0 -> dat 0, busy 0, sb_cnt 0. Write x0 = 0xDEADBEEF via wbck0 -> x0 still reads 0.
- wbck0 writes x3 = 0x12345678 while read_src1_idx = 3 -> BYPASS = 1: same-cycle read 0x12345678; BYPASS = 0: old value 0, then 0x12345678 the next cycle.
- Both ports write x7 (port 0 = 0xAAAA0000, port 1 = 0x5555FFFF) with x7 busy -> x7 = 0xAAAA0000, busy[7] cleared, sb_cnt decremented by 1.
- sb_set x9 -> next cycle busy 1, sb_cnt 1, sb_set_rdy for x9 = 0. Second set of x9 is held off. wbck1 x9 = 0x77 -> same cycle read 0x77 with busy 0 (BYPASS = 1); the set issued in that same cycle is accepted, busy stays 1, sb_cnt stays 1.
- Set x1, x2, x4 over three cycles -> sb_cnt 3. Assert sb_flush together with a set of x5 -> all busy 0, sb_cnt 0.
- Assert rst_n low mid-operation with busy bits set and registers written -> immediately all data 0, busy 0, sb_cnt 0, without a clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with dual write-back, optional bypass and busy scoreboard
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int RF_AW  = 5,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RF_AW-1:0]   read_src1_idx,
  input  logic [RF_AW-1:0]   read_src2_idx,
  output logic [XLEN-1:0]    read_src1_dat,
  output logic [XLEN-1:0]    read_src2_dat,
  output logic               read_src1_busy,
  output logic               read_src2_busy,
  input  logic               wbck0_wen,
  input  logic [RF_AW-1:0]   wbck0_idx,
  input  logic [XLEN-1:0]    wbck0_dat,
  input  logic               wbck1_wen,
  input  logic [RF_AW-1:0]   wbck1_idx,
  input  logic [XLEN-1:0]    wbck1_dat,
  input  logic               sb_set_vld,
  input  logic [RF_AW-1:0]   sb_set_idx,
  output logic               sb_set_rdy,
  input  logic               sb_flush,
  output logic [RF_AW:0]     sb_cnt
);

  localparam logic [RF_AW:0] NREGS_L = (RF_AW+1)'(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [RF_AW:0]   cnt;
  logic [RF_AW:0]   cnt_nxt;
  logic             wr0_ok;
  logic             wr1_ok;
  logic             set_acc;
  logic             cnt_inc;
  logic             cnt_dec;

  // Index 0 and indices beyond the implemented registers are never stored.
  function automatic logic idx_ok(input logic [RF_AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NREGS_L);
  endfunction

  function automatic logic busy_at(input logic [RF_AW-1:0] idx);
    return idx_ok(idx) ? busy[idx] : 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] read_dat(input logic [RF_AW-1:0] idx);
    logic [XLEN-1:0] d;
    d = '0;
    if (idx_ok(idx)) begin
      d = regs[idx];
      if (BYPASS != 0) begin
        if (wbck0_wen && wbck0_idx == idx)
          d = wbck0_dat;
        else if (wbck1_wen && wbck1_idx == idx)
          d = wbck1_dat;
      end
    end
    return d;
  endfunction

  function automatic logic read_busy(input logic [RF_AW-1:0] idx);
    logic b;
    b = busy_at(idx);
    if ((BYPASS != 0) && wbck1_wen && wbck1_idx == idx)
      b = 1'b0;
    return b;
  endfunction

  always_comb begin
    read_src1_dat  = read_dat(read_src1_idx);
    read_src2_dat  = read_dat(read_src2_idx);
    read_src1_busy = read_busy(read_src1_idx);
    read_src2_busy = read_busy(read_src2_idx);
  end

  assign sb_set_rdy = ~busy_at(sb_set_idx) | (wbck1_wen & (wbck1_idx == sb_set_idx));
  assign sb_cnt     = cnt;

  assign wr0_ok  = wbck0_wen & idx_ok(wbck0_idx);
  assign wr1_ok  = wbck1_wen & idx_ok(wbck1_idx);
  assign set_acc = sb_set_vld & sb_set_rdy & idx_ok(sb_set_idx);

  // A set of the register being cleared wins, so that clear must not decrement.
  assign cnt_inc = set_acc & ~busy_at(sb_set_idx);
  assign cnt_dec = wr1_ok & busy_at(wbck1_idx) & ~(set_acc & (sb_set_idx == wbck1_idx));

  always_comb begin
    busy_nxt = busy;
    if (wr1_ok)
      busy_nxt[wbck1_idx] = 1'b0;
    if (set_acc)
      busy_nxt[sb_set_idx] = 1'b1;
    if (sb_flush)
      busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (sb_flush)
      cnt_nxt = '0;
    else if (cnt_inc && !cnt_dec)
      cnt_nxt = cnt + 1'b1;
    else if (cnt_dec && !cnt_inc)
      cnt_nxt = cnt - 1'b1;
  end

  // Port 1 is written first so a same-index port 0 write overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      if (wr1_ok)
        regs[wbck1_idx] <= wbck1_dat;
      if (wr0_ok)
        regs[wbck0_idx] <= wbck0_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed check of regfile_sb against an array model
module tb_regfile_sb;

  localparam int BYP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  s1_idx, s2_idx;
  logic [31:0] s1_dat, s2_dat;
  logic        s1_busy, s2_busy;
  logic        w0_wen, w1_wen;
  logic [4:0]  w0_idx, w1_idx;
  logic [31:0] w0_dat, w1_dat;
  logic        set_vld, set_rdy, flush;
  logic [4:0]  set_idx;
  logic [5:0]  cnt;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          n_vec = 0;
  int          n_err = 0;

  regfile_sb #(.XLEN(32), .NREGS(32), .RF_AW(5), .BYPASS(BYP)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_src1_idx(s1_idx), .read_src2_idx(s2_idx),
    .read_src1_dat(s1_dat), .read_src2_dat(s2_dat),
    .read_src1_busy(s1_busy), .read_src2_busy(s2_busy),
    .wbck0_wen(w0_wen), .wbck0_idx(w0_idx), .wbck0_dat(w0_dat),
    .wbck1_wen(w1_wen), .wbck1_idx(w1_idx), .wbck1_dat(w1_dat),
    .sb_set_vld(set_vld), .sb_set_idx(set_idx), .sb_set_rdy(set_rdy),
    .sb_flush(flush), .sb_cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_dat(input logic [4:0] i);
    if (i == 0) return 32'h0;
    if (BYP != 0 && w0_wen && w0_idx == i) return w0_dat;
    if (BYP != 0 && w1_wen && w1_idx == i) return w1_dat;
    return m_regs[i];
  endfunction

  function automatic logic exp_busy(input logic [4:0] i);
    if (BYP != 0 && w1_wen && w1_idx == i) return 1'b0;
    return m_busy[i];
  endfunction

  function automatic logic exp_rdy();
    return !m_busy[set_idx] || (w1_wen && w1_idx == set_idx);
  endfunction

  function automatic logic [31:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 32'(c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("src1_dat", s1_dat, exp_dat(s1_idx));
    chk("src2_dat", s2_dat, exp_dat(s2_idx));
    chk("src1_busy", 32'(s1_busy), 32'(exp_busy(s1_idx)));
    chk("src2_busy", 32'(s2_busy), 32'(exp_busy(s2_idx)));
    chk("set_rdy", 32'(set_rdy), 32'(exp_rdy()));
    chk("sb_cnt", 32'(cnt), exp_cnt());
  endtask

  task automatic model_update();
    bit rdy;
    rdy = exp_rdy();
    if (w1_wen && w1_idx != 0) m_regs[w1_idx] = w1_dat;
    if (w0_wen && w0_idx != 0) m_regs[w0_idx] = w0_dat;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (w1_wen) m_busy[w1_idx] = 1'b0;
      if (set_vld && rdy && set_idx != 0) m_busy[set_idx] = 1'b1;
    end
  endtask

  task automatic idle();
    w0_wen = 0; w0_idx = 0; w0_dat = 0;
    w1_wen = 0; w1_idx = 0; w1_dat = 0;
    set_vld = 0; set_idx = 0; flush = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
    idle();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    idle();
    s1_idx = 5; s2_idx = 0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    sample();
    chk("rst_x5", s1_dat, 32'h0);
    chk("rst_x5_busy", 32'(s1_busy), 32'h0);
    chk("rst_x0", s2_dat, 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    advance();

    w0_wen = 1; w0_idx = 0; w0_dat = 32'hDEADBEEF;
    cycle();
    sample();
    chk("x0_after_write", s2_dat, 32'h0);
    advance();

    s1_idx = 3;
    w0_wen = 1; w0_idx = 3; w0_dat = 32'h12345678;
    sample();
    chk("x3_bypass", s1_dat, 32'h12345678);
    advance();
    sample();
    chk("x3_array", s1_dat, 32'h12345678);
    advance();

    s1_idx = 7;
    set_vld = 1; set_idx = 7;
    cycle();
    w0_wen = 1; w0_idx = 7; w0_dat = 32'hAAAA0000;
    w1_wen = 1; w1_idx = 7; w1_dat = 32'h5555FFFF;
    sample();
    chk("x7_pre_cnt", 32'(cnt), 32'h1);
    advance();
    sample();
    chk("x7_dat", s1_dat, 32'hAAAA0000);
    chk("x7_busy", 32'(s1_busy), 32'h0);
    chk("x7_cnt", 32'(cnt), 32'h0);
    advance();

    s1_idx = 9;
    set_vld = 1; set_idx = 9;
    cycle();
    set_vld = 1; set_idx = 9;
    sample();
    chk("x9_busy", 32'(s1_busy), 32'h1);
    chk("x9_cnt", 32'(cnt), 32'h1);
    chk("x9_rdy", 32'(set_rdy), 32'h0);
    advance();
    set_vld = 1; set_idx = 9;
    w1_wen = 1; w1_idx = 9; w1_dat = 32'h77;
    sample();
    chk("x9_wb_dat", s1_dat, 32'h77);
    chk("x9_wb_busy", 32'(s1_busy), 32'h0);
    chk("x9_wb_rdy", 32'(set_rdy), 32'h1);
    advance();
    sample();
    chk("x9_reset_busy", 32'(s1_busy), 32'h1);
    chk("x9_reset_cnt", 32'(cnt), 32'h1);
    advance();

    w1_wen = 1; w1_idx = 9; w1_dat = 32'h78;
    cycle();
    set_vld = 1; set_idx = 1; cycle();
    set_vld = 1; set_idx = 2; cycle();
    set_vld = 1; set_idx = 4; cycle();
    s1_idx = 4;
    sample();
    chk("cnt3", 32'(cnt), 32'h3);
    advance();
    set_vld = 1; set_idx = 5; flush = 1;
    cycle();
    s2_idx = 5;
    sample();
    chk("flush_cnt", 32'(cnt), 32'h0);
    chk("flush_busy4", 32'(s1_busy), 32'h0);
    chk("flush_busy5", 32'(s2_busy), 32'h0);
    advance();

    for (int n = 0; n < 3000; n++) begin
      s1_idx  = 5'($urandom_range(0, 11));
      s2_idx  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
      w0_wen  = ($urandom_range(0, 2) == 0);
      w0_idx  = 5'($urandom_range(0, 11));
      w0_dat  = $urandom;
      w1_wen  = ($urandom_range(0, 3) == 0);
      w1_idx  = 5'($urandom_range(0, 11));
      w1_dat  = $urandom;
      set_vld = ($urandom_range(0, 4) < 2);
      set_idx = 5'($urandom_range(0, 11));
      flush   = ($urandom_range(0, 39) == 0);
      cycle();
    end

    for (int i = 1; i < 5; i++) begin
      set_vld = 1; set_idx = 5'(i);
      w0_wen = 1; w0_idx = 5'(i + 10); w0_dat = 32'hC0DE0000 + i;
      cycle();
    end
    s1_idx = 11; s2_idx = 3;
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_dat1", s1_dat, 32'h0);
    chk("arst_busy2", 32'(s2_busy), 32'h0);
    chk("arst_cnt", 32'(cnt), 32'h0);
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
